// File: rtl/de_pipe_reg_pkg.sv
// Shared instruction-type encodings, Tnew constants and the E-stage record for the D->E pipe register.
package de_pipe_reg_pkg;

   localparam logic [2:0] TYPE_R = 3'd0;
   localparam logic [2:0] TYPE_I = 3'd1;
   localparam logic [2:0] TYPE_B = 3'd2;
   localparam logic [2:0] TYPE_J = 3'd3;
   localparam logic [2:0] TYPE_L = 3'd4;
   localparam logic [2:0] TYPE_S = 3'd5;

   localparam logic [1:0] TNEW_0 = 2'd0;
   localparam logic [1:0] TNEW_1 = 2'd1;
   localparam logic [1:0] TNEW_2 = 2'd2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] ext;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  reg_addr;
      logic [3:0]  op_alu;
      logic [1:0]  alu_src_a;
      logic [1:0]  alu_src_b;
      logic [2:0]  load_type;
      logic [1:0]  store_type;
      logic        dm_we;
      logic        reg_write;
      logic [1:0]  reg_data_sel;
      logic [2:0]  type_instr;
      logic        type_jl;
      logic        valid;
      logic [1:0]  tnew;
   } stage_t;

endpackage

// File: rtl/de_tnew_gen.sv
// Combinational map from instruction type to Tnew; shared with the hazard unit.
module de_tnew_gen
   import de_pipe_reg_pkg::*;
(
   input  logic [2:0] TypeInstr,
   input  logic       TypeJl,
   output logic [1:0] Tnew
);

   always_comb begin
      Tnew = TNEW_0;
      // Link jumps produce PC+8, which is ready before E, so they override the type.
      if (!TypeJl) begin
         case (TypeInstr)
            TYPE_L:         Tnew = TNEW_2;
            TYPE_R, TYPE_I: Tnew = TNEW_1;
            TYPE_B, TYPE_J,
            TYPE_S:         Tnew = TNEW_0;
            default:        Tnew = TNEW_0;
         endcase
      end
   end

endmodule

// File: rtl/de_pipe_reg.sv
// D->E pipeline register with bubble insert, hold and Tnew capture.
// Define DE_BUBBLE_CNT_EN to build the bubble counter; otherwise bubble_cnt reads 0.
module de_pipe_reg
   import de_pipe_reg_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        clr,
   input  logic [31:0] D_PC,
   input  logic [31:0] D_Instr,
   input  logic [31:0] D_RD1,
   input  logic [31:0] D_RD2,
   input  logic [31:0] D_EXT,
   input  logic [4:0]  D_rs,
   input  logic [4:0]  D_rt,
   input  logic [4:0]  RegAddr,
   input  logic [3:0]  E_opALU,
   input  logic [1:0]  E_ALUsrcA,
   input  logic [1:0]  E_ALUsrcB,
   input  logic [2:0]  M_loadType,
   input  logic [1:0]  M_storeType,
   input  logic        M_DMWE,
   input  logic        W_regWrite,
   input  logic [1:0]  RegDataSel,
   input  logic [2:0]  TypeInstr,
   input  logic        TypeJl,
   output logic [31:0] E_PC,
   output logic [31:0] E_Instr,
   output logic [31:0] E_RD1,
   output logic [31:0] E_RD2,
   output logic [31:0] E_EXT,
   output logic [4:0]  E_rs,
   output logic [4:0]  E_rt,
   output logic [4:0]  E_RegAddr,
   output logic [3:0]  E_E_opALU,
   output logic [1:0]  E_E_ALUsrcA,
   output logic [1:0]  E_E_ALUsrcB,
   output logic [2:0]  E_M_loadType,
   output logic [1:0]  E_M_storeType,
   output logic        E_M_DMWE,
   output logic        E_W_regWrite,
   output logic [1:0]  E_RegDataSel,
   output logic [2:0]  E_TypeInstr,
   output logic        E_TypeJl,
   output logic        E_valid,
   output logic [1:0]  E_Tnew,
   output logic [31:0] bubble_cnt
);

   stage_t     e_q;
   logic [1:0] tnew_d;

   de_tnew_gen u_tnew (
      .TypeInstr (TypeInstr),
      .TypeJl    (TypeJl),
      .Tnew      (tnew_d)
   );

`ifdef DE_BUBBLE_CNT_EN
   logic [31:0] cnt_q;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_q <= '0;
`ifdef DE_BUBBLE_CNT_EN
         cnt_q <= '0;
`endif
      end else begin
         if (clr) begin
            // Bubble keeps its PC so exception/debug logic can still see where it came from.
            e_q    <= '0;
            e_q.pc <= D_PC;
         end else if (en) begin
            e_q.pc           <= D_PC;
            e_q.instr        <= D_Instr;
            e_q.rd1          <= D_RD1;
            e_q.rd2          <= D_RD2;
            e_q.ext          <= D_EXT;
            e_q.rs           <= D_rs;
            e_q.rt           <= D_rt;
            e_q.reg_addr     <= RegAddr;
            e_q.op_alu       <= E_opALU;
            e_q.alu_src_a    <= E_ALUsrcA;
            e_q.alu_src_b    <= E_ALUsrcB;
            e_q.load_type    <= M_loadType;
            e_q.store_type   <= M_storeType;
            e_q.dm_we        <= M_DMWE;
            e_q.reg_write    <= W_regWrite;
            e_q.reg_data_sel <= RegDataSel;
            e_q.type_instr   <= TypeInstr;
            e_q.type_jl      <= TypeJl;
            e_q.valid        <= 1'b1;
            e_q.tnew         <= tnew_d;
         end
`ifdef DE_BUBBLE_CNT_EN
         if (clr) cnt_q <= cnt_q + 32'd1;
`endif
      end
   end

`ifdef DE_BUBBLE_CNT_EN
   assign bubble_cnt = cnt_q;
`else
   assign bubble_cnt = 32'h0;
`endif

   assign E_PC          = e_q.pc;
   assign E_Instr       = e_q.instr;
   assign E_RD1         = e_q.rd1;
   assign E_RD2         = e_q.rd2;
   assign E_EXT         = e_q.ext;
   assign E_rs          = e_q.rs;
   assign E_rt          = e_q.rt;
   assign E_RegAddr     = e_q.reg_addr;
   assign E_E_opALU     = e_q.op_alu;
   assign E_E_ALUsrcA   = e_q.alu_src_a;
   assign E_E_ALUsrcB   = e_q.alu_src_b;
   assign E_M_loadType  = e_q.load_type;
   assign E_M_storeType = e_q.store_type;
   assign E_M_DMWE      = e_q.dm_we;
   assign E_W_regWrite  = e_q.reg_write;
   assign E_RegDataSel  = e_q.reg_data_sel;
   assign E_TypeInstr   = e_q.type_instr;
   assign E_TypeJl      = e_q.type_jl;
   assign E_valid       = e_q.valid;
   assign E_Tnew        = e_q.tnew;

endmodule

// File: tb/tb_de_pipe_reg.sv
// Scoreboard bench for de_pipe_reg: random and directed D-stage traffic against a rule-level model.
module tb_de_pipe_reg;
   import de_pipe_reg_pkg::*;

   typedef struct packed {
      logic [31:0] pc, instr, rd1, rd2, ext;
      logic [4:0]  rs, rt, reg_addr;
      logic [3:0]  op_alu;
      logic [1:0]  src_a, src_b;
      logic [2:0]  load_type;
      logic [1:0]  store_type;
      logic        dm_we, reg_write;
      logic [1:0]  reg_data_sel;
      logic [2:0]  type_instr;
      logic        type_jl;
   } din_t;

   typedef struct packed {
      din_t        d;
      logic        valid;
      logic [1:0]  tnew;
      logic [31:0] cnt;
   } obs_t;

   logic clk = 1'b0;
   logic reset, en, clr;
   din_t din;
   obs_t act, m;
   obs_t q[$];
   int   n_checks = 0, n_pass = 0;

   logic [31:0] E_PC, E_Instr, E_RD1, E_RD2, E_EXT, bubble_cnt;
   logic [4:0]  E_rs, E_rt, E_RegAddr;
   logic [3:0]  E_E_opALU;
   logic [1:0]  E_E_ALUsrcA, E_E_ALUsrcB, E_M_storeType, E_RegDataSel, E_Tnew;
   logic [2:0]  E_M_loadType, E_TypeInstr;
   logic        E_M_DMWE, E_W_regWrite, E_TypeJl, E_valid;

   always #5 clk = ~clk;

   de_pipe_reg dut (
      .clk(clk), .reset(reset), .en(en), .clr(clr),
      .D_PC(din.pc), .D_Instr(din.instr), .D_RD1(din.rd1), .D_RD2(din.rd2), .D_EXT(din.ext),
      .D_rs(din.rs), .D_rt(din.rt), .RegAddr(din.reg_addr),
      .E_opALU(din.op_alu), .E_ALUsrcA(din.src_a), .E_ALUsrcB(din.src_b),
      .M_loadType(din.load_type), .M_storeType(din.store_type), .M_DMWE(din.dm_we),
      .W_regWrite(din.reg_write), .RegDataSel(din.reg_data_sel),
      .TypeInstr(din.type_instr), .TypeJl(din.type_jl),
      .E_PC(E_PC), .E_Instr(E_Instr), .E_RD1(E_RD1), .E_RD2(E_RD2), .E_EXT(E_EXT),
      .E_rs(E_rs), .E_rt(E_rt), .E_RegAddr(E_RegAddr),
      .E_E_opALU(E_E_opALU), .E_E_ALUsrcA(E_E_ALUsrcA), .E_E_ALUsrcB(E_E_ALUsrcB),
      .E_M_loadType(E_M_loadType), .E_M_storeType(E_M_storeType), .E_M_DMWE(E_M_DMWE),
      .E_W_regWrite(E_W_regWrite), .E_RegDataSel(E_RegDataSel),
      .E_TypeInstr(E_TypeInstr), .E_TypeJl(E_TypeJl),
      .E_valid(E_valid), .E_Tnew(E_Tnew), .bubble_cnt(bubble_cnt)
   );

   assign act = {E_PC, E_Instr, E_RD1, E_RD2, E_EXT, E_rs, E_rt, E_RegAddr,
                 E_E_opALU, E_E_ALUsrcA, E_E_ALUsrcB, E_M_loadType, E_M_storeType,
                 E_M_DMWE, E_W_regWrite, E_RegDataSel, E_TypeInstr, E_TypeJl,
                 E_valid, E_Tnew, bubble_cnt};

   function automatic logic [1:0] ref_tnew(input logic [2:0] t, input logic jl);
      if (jl)                         return 2'd0;
      if (t == TYPE_L)                return 2'd2;
      if (t == TYPE_R || t == TYPE_I) return 2'd1;
      return 2'd0;
   endfunction

   function automatic din_t rand_din();
      din_t d;
      d.pc = $urandom; d.instr = $urandom; d.rd1 = $urandom; d.rd2 = $urandom; d.ext = $urandom;
      d.rs = 5'($urandom); d.rt = 5'($urandom); d.reg_addr = 5'($urandom);
      d.op_alu = 4'($urandom); d.src_a = 2'($urandom); d.src_b = 2'($urandom);
      d.load_type = 3'($urandom); d.store_type = 2'($urandom);
      d.dm_we = 1'($urandom); d.reg_write = 1'($urandom); d.reg_data_sel = 2'($urandom);
      d.type_instr = 3'($urandom); d.type_jl = ($urandom_range(0, 5) == 0);
      return d;
   endfunction

   task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, a, e);
   endtask

   // Drive one edge's inputs and queue what the E stage must show after that edge.
   task automatic step(input din_t d, input logic e, input logic c);
      @(negedge clk);
      din = d; en = e; clr = c;
      if (c) begin
         m.d = '0; m.d.pc = d.pc; m.valid = 1'b0; m.tnew = 2'd0;
`ifdef DE_BUBBLE_CNT_EN
         m.cnt = m.cnt + 32'd1;
`endif
      end else if (e) begin
         m.d = d; m.valid = 1'b1; m.tnew = ref_tnew(d.type_instr, d.type_jl);
      end
      q.push_back(m);
   endtask

   // Wait for the monitor to consume everything, then park the DUT in hold.
   task automatic drain();
      int k;
      for (k = 0; k < 5 && q.size() != 0; k++) begin
         @(posedge clk); #2;
      end
      if (q.size() != 0) begin
         n_checks++;
         $display("FAIL drain_timeout: %0d entries left expected 0", q.size());
         q.delete();
      end
      en = 1'b0; clr = 1'b0;
   endtask

   initial begin : monitor
      obs_t e;
      forever begin
         @(posedge clk); #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            n_checks++;
            if (act === e) n_pass++;
            else $display("FAIL scoreboard: got %h expected %h", act, e);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      din_t d;
      reset = 1'b0; en = 1'b1; clr = 1'b0; din = rand_din(); m = '0;
      #3;
      check("reset_all_zero_pc", E_PC, 32'h0);
      check("reset_all_zero_any", 32'(|act), 32'h0);
      @(negedge clk); reset = 1'b1; en = 1'b0;

      // lw load
      d = rand_din(); d.pc = 32'h0000_3004; d.type_instr = TYPE_L; d.type_jl = 1'b0; d.reg_addr = 5'd8;
      step(d, 1'b1, 1'b0); drain();
      check("load_pc", E_PC, 32'h0000_3004);
      check("load_regaddr", 32'(E_RegAddr), 32'd8);
      check("load_tnew", 32'(E_Tnew), 32'd2);
      check("load_valid", 32'(E_valid), 32'd1);

      // hold for 3 edges while D_PC moves on
      d = rand_din(); d.pc = 32'h0000_3008; d.type_instr = TYPE_R; d.type_jl = 1'b0;
      step(d, 1'b1, 1'b0);
      d.pc = 32'h0000_300C;
      repeat (3) step(d, 1'b0, 1'b0);
      drain();
      check("hold_pc", E_PC, 32'h0000_3008);
      check("hold_tnew", 32'(E_Tnew), 32'd1);

      // clr beats !en
      d = rand_din(); d.pc = 32'h0000_3010; d.reg_write = 1'b1; d.dm_we = 1'b1;
      step(d, 1'b0, 1'b1); drain();
      check("bubble_pc", E_PC, 32'h0000_3010);
      check("bubble_regwrite", 32'(E_W_regWrite), 32'd0);
      check("bubble_dmwe", 32'(E_M_DMWE), 32'd0);
      check("bubble_valid", 32'(E_valid), 32'd0);
      check("bubble_tnew", 32'(E_Tnew), 32'd0);
      check("bubble_regaddr", 32'(E_RegAddr), 32'd0);

      // jal
      d = rand_din(); d.type_jl = 1'b1; d.type_instr = TYPE_J; d.reg_addr = 5'd31;
      d.reg_data_sel = 2'd2; d.reg_write = 1'b1;
      step(d, 1'b1, 1'b0); drain();
      check("jal_tnew", 32'(E_Tnew), 32'd0);
      check("jal_regaddr", 32'(E_RegAddr), 32'd31);
      check("jal_regwrite", 32'(E_W_regWrite), 32'd1);

      // asynchronous reset 3ns after an edge with valid data loaded
      d = rand_din(); d.type_instr = TYPE_L; d.type_jl = 1'b0; d.pc = 32'h0000_4000;
      step(d, 1'b1, 1'b0); drain();
      @(posedge clk); #3; reset = 1'b0; #1;
      check("async_reset_pc", E_PC, 32'h0);
      check("async_reset_valid", 32'(E_valid), 32'd0);
      check("async_reset_tnew", 32'(E_Tnew), 32'd0);
      check("async_reset_cnt", bubble_cnt, 32'h0);
      m = '0;
      @(negedge clk); reset = 1'b1;

      // counter: five back-to-back bubbles, then wrap
      for (int i = 0; i < 5; i++) step(rand_din(), 1'($urandom), 1'b1);
      drain();
`ifdef DE_BUBBLE_CNT_EN
      check("cnt_five", bubble_cnt, 32'd5);
      @(negedge clk);
      force dut.cnt_q = 32'hFFFF_FFFF;
      #1 release dut.cnt_q;
      m.cnt = 32'hFFFF_FFFF;
`else
      check("cnt_five", bubble_cnt, 32'd0);
`endif
      step(rand_din(), 1'b1, 1'b1); drain();
      check("cnt_wrap", bubble_cnt, 32'd0);

      // random traffic
      for (int i = 0; i < 300; i++)
         step(rand_din(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0));
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
